// File: rtl/hamming_enc_seq_if.sv
// Bundle of the job-control, data-memory and shared-ALU signals of the
// Hamming(16,11) sequential encoder.
//
// Handshake: start is a one-cycle request that the encoder accepts only while
// idle. Job parameters travel with start. busy is high while a job is in
// flight. done pulses for exactly one cycle when the job ends. The memory read
// and ALU result are combinational responses to the address and operands
// driven in the same cycle. A memory write occurs at the clock edge ending any
// cycle with mem_wr_en high.
//
// Modports:
//   master - the encoder: drives the memory/ALU buses and the status signals
//   slave  - the environment: host, data memory and team ALU
interface hamming_enc_seq_if;
    logic       start;
    logic [7:0] src_base;
    logic [7:0] dst_base;
    logic [4:0] count;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_rslt;
    logic       busy;
    logic       done;
    logic [4:0] words_done;
    logic [3:0] state_dbg;

    modport master (
        input  start, src_base, dst_base, count, mem_rd_data, alu_rslt,
        output mem_addr, mem_wr_en, mem_wr_data, alu_op, alu_a, alu_b,
               busy, done, words_done, state_dbg
    );

    modport slave (
        output start, src_base, dst_base, count, mem_rd_data, alu_rslt,
        input  mem_addr, mem_wr_en, mem_wr_data, alu_op, alu_a, alu_b,
               busy, done, words_done, state_dbg
    );
endinterface

// File: rtl/hamming_enc_seq.sv
// Sequential Hamming(16,11) SECDED encoder. For each of count words it reads
// an 11-bit raw word (LSW, then MSW[2:0]) from data memory, builds the 16-bit
// codeword through a shared combinational ALU, and writes it back as LSW then
// MSW. Every state lasts one cycle, so a word takes 11 cycles.
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high
//   bus   - hamming_enc_seq_if.master: job control (start, src_base,
//           dst_base, count, busy, done, words_done), data memory
//           (mem_addr, mem_rd_data, mem_wr_en, mem_wr_data), ALU
//           (alu_op, alu_a, alu_b, alu_rslt) and the state_dbg view
module hamming_enc_seq (
    input  logic               clk,
    input  logic               reset,
    hamming_enc_seq_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE, RD_L, RD_M, PK_L, PK_M, P1, P2, P4, P8, P0, WR_L, WR_M, FIN
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] src, dst;
    logic [4:0] cnt;
    logic [7:0] raw_l, raw_m;
    logic [7:0] enc_l, enc_m;
    logic [4:0] words_done;
    logic [7:0] word_ofs;

    // words_done doubles as the index k of the word being processed, so
    // 2k is just words_done shifted left. Adds wrap modulo 256.
    assign word_ofs = {2'b00, words_done, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.mem_addr    = 8'h00;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'h00;
        bus.alu_op      = 4'h0;
        bus.alu_a       = 8'h00;
        bus.alu_b       = 8'h00;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = (bus.count != 5'd0) ? RD_L : FIN;
            end
            RD_L: begin
                bus.mem_addr = src + word_ofs;
                state_nxt    = RD_M;
            end
            RD_M: begin
                bus.mem_addr = src + word_ofs + 8'd1;
                state_nxt    = PK_L;
            end
            PK_L: begin
                bus.alu_op = 4'hD;
                bus.alu_a  = raw_l;
                state_nxt  = PK_M;
            end
            PK_M: begin
                bus.alu_op = 4'hE;
                bus.alu_a  = raw_l;
                bus.alu_b  = raw_m;
                state_nxt  = P1;
            end
            P1: begin
                bus.alu_op = 4'h9;
                bus.alu_a  = raw_l;
                bus.alu_b  = raw_m;
                state_nxt  = P2;
            end
            P2: begin
                bus.alu_op = 4'hA;
                bus.alu_a  = raw_l;
                bus.alu_b  = raw_m;
                state_nxt  = P4;
            end
            P4: begin
                bus.alu_op = 4'hB;
                bus.alu_a  = raw_l;
                bus.alu_b  = raw_m;
                state_nxt  = P8;
            end
            P8: begin
                bus.alu_op = 4'hC;
                bus.alu_a  = raw_l;
                bus.alu_b  = raw_m;
                state_nxt  = P0;
            end
            P0: begin
                // Overall parity covers the codeword built so far.
                bus.alu_op = 4'h8;
                bus.alu_a  = enc_l;
                bus.alu_b  = enc_m;
                state_nxt  = WR_L;
            end
            WR_L: begin
                bus.mem_addr    = dst + word_ofs;
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = enc_l;
                state_nxt       = WR_M;
            end
            WR_M: begin
                bus.mem_addr    = dst + word_ofs + 8'd1;
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = enc_m;
                // Compare against the post-increment count, one bit wider so
                // the add cannot wrap.
                state_nxt = (({1'b0, words_done} + 6'd1) < {1'b0, cnt}) ? RD_L : FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src        <= 8'h00;
            dst        <= 8'h00;
            cnt        <= 5'd0;
            raw_l      <= 8'h00;
            raw_m      <= 8'h00;
            enc_l      <= 8'h00;
            enc_m      <= 8'h00;
            words_done <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src        <= bus.src_base;
                        dst        <= bus.dst_base;
                        cnt        <= bus.count;
                        words_done <= 5'd0;
                    end
                end
                RD_L:       raw_l <= bus.mem_rd_data;
                RD_M:       raw_m <= bus.mem_rd_data;
                PK_L:       enc_l <= bus.alu_rslt;
                PK_M:       enc_m <= bus.alu_rslt;
                P1, P2, P4: enc_l <= enc_l | bus.alu_rslt;
                P8:         enc_m <= enc_m | {7'b0, bus.alu_rslt[0]};
                P0:         enc_l <= enc_l | {7'b0, bus.alu_rslt[0]};
                WR_M:       words_done <= words_done + 5'd1;
                default:    ;
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FIN);
    assign bus.words_done = words_done;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_hamming_enc_seq.sv
// Bench for hamming_enc_seq: models the data memory and the team ALU,
// issues directed jobs with hand-computed codewords, and checks every memory
// write and every done pulse against expectation queues.
module tb_hamming_enc_seq;
  logic clk;
  logic reset;
  hamming_enc_seq_if bus();

  hamming_enc_seq dut (.clk(clk), .reset(reset), .bus(bus));

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment models ----------------
  logic [7:0] mem [256];
  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en === 1'b1) mem[bus.mem_addr] <= bus.mem_wr_data;

  // Team ALU: data bit d0..d10 sits at codeword positions 3,5,6,7,9..15.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [10:0] d;
    logic p1, p2, p4, p8;
    d  = {b[2:0], a};
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    p8 = ^d[10:4];
    case (op)
      4'h8:    return {7'b0, ^{a, b}};
      4'h9:    return {6'b0, p1, 1'b0};
      4'hA:    return {5'b0, p2, 2'b0};
      4'hB:    return {3'b0, p4, 4'b0};
      4'hC:    return {7'b0, p8};
      4'hD:    return {a[3], a[2], a[1], 1'b0, a[0], 3'b000};
      4'hE:    return {b[2:0], a[7:4], 1'b0};
      default: return 8'h5A;
    endcase
  endfunction
  assign bus.alu_rslt = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];   // {addr, data} of each expected write
  int          done_q[$];  // expected cycle of each done pulse
  logic [4:0]  wd_q[$];    // expected words_done at each done pulse

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)",
                 bus.mem_addr, bus.mem_wr_data, cyc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'b0, bus.mem_addr}, {24'b0, e[15:8]});
        check("wr_data", {24'b0, bus.mem_wr_data}, {24'b0, e[7:0]});
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
        check("words_done", {27'b0, bus.words_done}, {27'b0, wd_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Call from a negedge; start is high for the cycle beginning there.
  task automatic start_job(input logic [7:0] s, input logic [7:0] d, input logic [4:0] n,
                           input bit expect_done, output int start_cyc);
    bus.start    = 1'b1;
    bus.src_base = s;
    bus.dst_base = d;
    bus.count    = n;
    start_cyc    = cyc;
    if (expect_done) begin
      done_q.push_back(cyc + 11 * int'(n) + 1);
      wd_q.push_back(n);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.src_base = 8'h00;
    bus.dst_base = 8'h00;
    bus.count    = 5'd0;
  endtask

  task automatic wait_done(input int c0, input int budget);
    for (int i = 0; i < budget && done_cnt == c0; i++) @(negedge clk);
    if (done_cnt == c0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", budget);
    end
    @(negedge clk);
    check("writes_left", exp_q.size(), 0);
  endtask

  task automatic run_job(input logic [7:0] s, input logic [7:0] d, input logic [4:0] n);
    int c0, sc;
    c0 = done_cnt;
    start_job(s, d, n, 1'b1, sc);
    wait_done(c0, 11 * int'(n) + 20);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  {31'b0, bus.busy}, 0);
    check({tag, "_done"},  {31'b0, bus.done}, 0);
    check({tag, "_wr_en"}, {31'b0, bus.mem_wr_en}, 0);
    check({tag, "_alu_op"}, {28'b0, bus.alu_op}, 0);
    check({tag, "_addr"},  {24'b0, bus.mem_addr}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int sc, c0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.src_base = 8'h00;
    bus.dst_base = 8'h00;
    bus.count    = 5'd0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_words_done", {27'b0, bus.words_done}, 0);
    reset = 1'b0;
    @(negedge clk);

    // data 0x001 -> codeword 0x000F
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h00;
    push_wr(8'h40, 8'h0F); push_wr(8'h41, 8'h00);
    run_job(8'h10, 8'h40, 5'd1);

    // data 0x7FF -> 0xFFFF; MSW[7:3] set must not matter
    mem[8'h12] = 8'hFF; mem[8'h13] = 8'h07;
    push_wr(8'h42, 8'hFF); push_wr(8'h43, 8'hFF);
    run_job(8'h12, 8'h42, 5'd1);
    mem[8'h14] = 8'hFF; mem[8'h15] = 8'hFF;
    push_wr(8'h44, 8'hFF); push_wr(8'h45, 8'hFF);
    run_job(8'h14, 8'h44, 5'd1);

    // empty job: done one cycle after start, no writes
    run_job(8'h20, 8'h50, 5'd0);
    check("zero_job_mem", {24'b0, mem[8'h50]}, 32'hAA);
    check_idle("after_zero");

    // wrapping job: 0x010 -> 0x0303, 0x400 -> 0x8117, 0x001 -> 0x000F
    mem[8'hFE] = 8'h10; mem[8'hFF] = 8'h00;
    mem[8'h00] = 8'h00; mem[8'h01] = 8'h04;
    mem[8'h02] = 8'h01; mem[8'h03] = 8'h00;
    push_wr(8'hFC, 8'h03); push_wr(8'hFD, 8'h03);
    push_wr(8'hFE, 8'h17); push_wr(8'hFF, 8'h81);
    push_wr(8'h00, 8'h0F); push_wr(8'h01, 8'h00);
    run_job(8'hFE, 8'hFC, 5'd3);

    // reset during P4 of the second word
    mem[8'h60] = 8'h01; mem[8'h61] = 8'h00;
    mem[8'h62] = 8'hFF; mem[8'h63] = 8'h07;
    mem[8'h64] = 8'h00; mem[8'h65] = 8'h00;
    push_wr(8'h70, 8'h0F); push_wr(8'h71, 8'h00);
    start_job(8'h60, 8'h70, 5'd3, 1'b0, sc);
    while (cyc < sc + 18) @(negedge clk);
    check("mid_state_p4", {28'b0, bus.state_dbg}, 7);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_words_done", {27'b0, bus.words_done}, 0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check_idle("after_abort");
    check("abort_w1_l", {24'b0, mem[8'h70]}, 32'h0F);
    check("abort_w1_m", {24'b0, mem[8'h71]}, 32'h00);
    check("abort_w2_l", {24'b0, mem[8'h72]}, 32'hAA);
    check("abort_w2_m", {24'b0, mem[8'h73]}, 32'hAA);
    check("abort_writes_left", exp_q.size(), 0);

    // start pulses while busy and during FIN are ignored
    mem[8'h80] = 8'h00; mem[8'h81] = 8'h04;
    mem[8'h82] = 8'h10; mem[8'h83] = 8'h00;
    push_wr(8'h88, 8'h17); push_wr(8'h89, 8'h81);
    push_wr(8'h8A, 8'h03); push_wr(8'h8B, 8'h03);
    c0 = done_cnt;
    start_job(8'h80, 8'h88, 5'd2, 1'b1, sc);
    while (cyc < sc + 5) @(negedge clk);
    check("busy_mid_job", {31'b0, bus.busy}, 1);
    bus.start = 1'b1; bus.src_base = 8'h10; bus.dst_base = 8'hC0; bus.count = 5'd5;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < sc + 23) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.src_base = 8'h00; bus.dst_base = 8'h00; bus.count = 5'd0;
    wait_done(c0, 10);
    repeat (3) @(negedge clk);
    check_idle("after_ignored");
    check("ignored_dst", {24'b0, mem[8'hC0]}, 32'hAA);
    check("final_words_done", {27'b0, bus.words_done}, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_enc_seq.md
HAMMING_ENC_SEQ -- requirements
Module: hamming_enc_seq

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port start  in  1  one-cycle request to begin a job; sampled only in IDLE.
REQ-004 SHALL have port src_base  in  8  address of the first raw LSW; sampled with start.
REQ-005 SHALL have port dst_base  in  8  address of the first encoded LSW; sampled with start.
REQ-006 SHALL have port count  in  5  number of 11-bit words to encode (0-31); sampled with start.
REQ-007 SHALL have port mem_addr  out  8  data-memory address.
REQ-008 SHALL have port mem_rd_data  in  8  data-memory read data; combinational read of mem_addr in the same cycle.
REQ-009 SHALL have port mem_wr_en  out  1  write strobe; memory writes mem_wr_data to mem_addr at the clock edge.
REQ-010 SHALL have port mem_wr_data  out  8  write data.
REQ-011 SHALL have port alu_op  out  4  command to the shared combinational team ALU.
REQ-012 SHALL have ports alu_a and alu_b  out  8 each  ALU operands.
REQ-013 SHALL have port alu_rslt  in  8  ALU result, valid in the same cycle.
REQ-014 SHALL have port busy  out  1  high from the cycle after start is accepted until done.
REQ-015 SHALL have port done  out  1  one-cycle pulse at job end.
REQ-016 SHALL have port words_done  out  5  count of words fully written in the current or last job.

Function
REQ-017 SHALL implement states IDLE, RD_L, RD_M, PK_L, PK_M, P1, P2, P4, P8, P0, WR_L, WR_M, and FIN, each lasting exactly one cycle.
REQ-018 SHALL, in IDLE with start=1, latch src_base, dst_base, and count, clear words_done, and go to RD_L when count!=0 or to FIN when count=0.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL, for word k, read from address src_base+2k in RD_L into raw_l, and from src_base+2k+1 in RD_M into raw_m; raw_m[7:3] is don't-care.
REQ-021 SHALL drive alu_op=4'hD in PK_L with alu_a=raw_l, and latch alu_rslt into enc_l.
REQ-022 SHALL drive alu_op=4'hE in PK_M with alu_a=raw_l and alu_b=raw_m, and latch alu_rslt into enc_m.
REQ-023 SHALL drive alu_op=4'h9/4'hA/4'hB in P1/P2/P4 with alu_a=raw_l and alu_b=raw_m, and apply enc_l |= alu_rslt.
REQ-024 SHALL drive alu_op=4'hC in P8 with alu_a=raw_l and alu_b=raw_m, and apply enc_m |= {7'b0, alu_rslt[0]}.
REQ-025 SHALL drive alu_op=4'h8 in P0 with alu_a=enc_l and alu_b=enc_m, and apply enc_l |= {7'b0, alu_rslt[0]}.
REQ-026 SHALL, in WR_L, assert mem_wr_en with mem_addr=dst_base+2k and mem_wr_data=enc_l.
REQ-027 SHALL, in WR_M, assert mem_wr_en with mem_addr=dst_base+2k+1 and mem_wr_data=enc_m, and increment words_done.
REQ-028 SHALL, after WR_M, go to RD_L when words_done (after increment) < count, or else to FIN.
REQ-029 SHALL take exactly 11 cycles per word; a job of N words finishes with done in cycle 11N+1 after the start cycle (N=0: cycle 1).
REQ-030 SHALL compute all address arithmetic modulo 256, wrapping past 8'hFF without error.
REQ-031 SHALL assert done for exactly one cycle in FIN, then return to IDLE with busy=0; a start seen during FIN is ignored.
REQ-032 SHALL drive alu_op=0, alu_a=0, alu_b=0, mem_wr_en=0, and mem_addr=0 in IDLE and FIN.
REQ-033 SHALL assert mem_wr_en only in WR_L and WR_M.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, enter IDLE and set busy=0, done=0, mem_wr_en=0, words_done=0, and clear all internal registers.
REQ-035 SHALL, on reset mid-job, abandon the job in the same edge with no further memory writes; words already written remain.
REQ-036 SHALL give reset priority over start when both are high.

Verification
REQ-037 SHALL be checked by: count=1, src word {LSW=8'h01, MSW=8'h00} -> dst gets 8'h0F then 8'h00, done in cycle 12.
REQ-038 SHALL be checked by: count=1, src {8'hFF, 8'h07} -> dst gets 8'hFF, 8'hFF; also {8'hFF, 8'hFF} -> the same result, showing MSW[7:3] is ignored.
REQ-039 SHALL be checked by: count=0 -> no write, done pulse at cycle 1, words_done=0.
REQ-040 SHALL be checked by: count=3, src_base=8'hFE, dst_base=8'hFC -> reads wrap through 8'h00-8'h03, six writes at FC-FF and 00-01, done in cycle 34, words_done=3.
REQ-041 SHALL be checked by: reset asserted during P4 of word 2 of 3 -> word 1 intact, no word-2 writes, busy=0 the next cycle.
REQ-042 SHALL be checked by: start pulsed while busy -> ignored, with job parameters unchanged.
